// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester, response and RAM-side signals of the
// two-port RAM arbiter, grouped so the arbiter, its requesters and the RAM
// model all share one bundle.
//
// Handshake: a request transfers in the cycle where reqN_valid and
// reqN_ready are both high at the rising edge. reqN_ready is combinational
// and may depend on reqN_valid. addr/din/we are sampled only in that cycle.
// rspN_valid is a one-cycle pulse with no backpressure; the requester must
// take rspN_dout in that cycle.
interface ram_port_arbiter_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 14
);
  logic              req0_valid;
  logic              req0_we;
  logic [AWIDTH-1:0] req0_addr;
  logic [DWIDTH-1:0] req0_din;
  logic              req0_ready;
  logic              req1_valid;
  logic              req1_we;
  logic [AWIDTH-1:0] req1_addr;
  logic [DWIDTH-1:0] req1_din;
  logic              req1_ready;
  logic              rsp0_valid;
  logic [DWIDTH-1:0] rsp0_dout;
  logic              rsp1_valid;
  logic [DWIDTH-1:0] rsp1_dout;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_din;
  logic              ram_we;
  logic [DWIDTH-1:0] ram_dout;
  logic              init_done;

  // Requester side.
  modport master (
    output req0_valid, req0_we, req0_addr, req0_din,
    output req1_valid, req1_we, req1_addr, req1_din,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_dout, rsp1_valid, rsp1_dout,
    input  init_done
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_din,
    input  req1_valid, req1_we, req1_addr, req1_din,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_dout, rsp1_valid, rsp1_dout,
    output ram_addr, ram_din, ram_we,
    input  ram_dout,
    output init_done
  );

  // RAM side.
  modport mem (
    input  ram_addr, ram_din, ram_we,
    output ram_dout
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter and sequencer placing two requesters
// onto one single-port, one-cycle-latency synchronous-read RAM. At most one
// grant per cycle; read data returns to the owner one cycle after its grant.
// Optional feature: define ARB_RAM_INIT_EN to sweep the RAM to zero after
// every reset before any request is accepted.
module ram_port_arbiter #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 14
) (
  input  logic              clock,
  input  logic              reset,
  ram_port_arbiter_if.slave bus,
  output logic              state_dbg
);
  typedef enum logic {INIT = 1'b0, ARB = 1'b1} state_t;

  state_t state;
  logic   rr_last;   // index of the most recently granted requester
  logic   grant0;
  logic   grant1;
  logic   rsp0_q;
  logic   rsp1_q;

`ifdef ARB_RAM_INIT_EN
  localparam int DEPTH = 1 << AWIDTH;

  state_t            state_nxt;
  logic [AWIDTH-1:0] init_cnt;

  // State register: every reset restarts the zero sweep.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  // Next state: leave INIT after the cycle that writes the last address.
  always_comb begin
    state_nxt = state;
    if (state == INIT && init_cnt == AWIDTH'(DEPTH - 1)) state_nxt = ARB;
  end

  // Sweep address counter, advancing once per INIT cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)               init_cnt <= '0;
    else if (state == INIT)  init_cnt <= init_cnt + AWIDTH'(1);
  end
`else
  assign state = ARB;
`endif

  // Grant selection: a lone request wins; a tie goes to the port not
  // granted most recently. No grants during reset or the sweep.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && state == ARB) begin
      if (bus.req0_valid && (!bus.req1_valid || rr_last)) grant0 = 1'b1;
      else if (bus.req1_valid)                            grant1 = 1'b1;
    end
  end

  // RAM drive: sweep writes in INIT, the granted request in ARB, idle zeros
  // otherwise. Held quiet while reset is asserted.
  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    if (!reset) begin
`ifdef ARB_RAM_INIT_EN
      if (state == INIT) begin
        bus.ram_we   = 1'b1;
        bus.ram_addr = init_cnt;
      end
`endif
      if (grant0) begin
        bus.ram_we   = bus.req0_we;
        bus.ram_addr = bus.req0_addr;
        bus.ram_din  = bus.req0_din;
      end else if (grant1) begin
        bus.ram_we   = bus.req1_we;
        bus.ram_addr = bus.req1_addr;
        bus.ram_din  = bus.req1_din;
      end
    end
  end

  // Round-robin history and one-cycle read response flags; reset drops any
  // response still in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_last <= 1'b1;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      if (grant0)      rr_last <= 1'b0;
      else if (grant1) rr_last <= 1'b1;
      rsp0_q <= grant0 && !bus.req0_we;
      rsp1_q <= grant1 && !bus.req1_we;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = rsp0_q;
  assign bus.rsp1_valid = rsp1_q;
  // The RAM read port is shared; rsp_valid tells each requester when it owns it.
  assign bus.rsp0_dout  = bus.ram_dout;
  assign bus.rsp1_dout  = bus.ram_dout;
  assign bus.init_done  = (state == ARB);
  assign state_dbg      = logic'(state);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized and directed stimulus for ram_port_arbiter
// against a behavioural model (memory array, last-grant index, pending
// response) plus a behavioural single-port RAM. Works in both builds
// (ARB_RAM_INIT_EN defined or not).
module tb_ram_port_arbiter;
  localparam int AWIDTH = 3;
  localparam int DWIDTH = 14;
  localparam int DEPTH  = 1 << AWIDTH;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic state_dbg;
  always #5 clock = ~clock;

  ram_port_arbiter_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

  ram_port_arbiter #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- RAM: write at the edge, read through latched address ----
  logic [DWIDTH-1:0] ram_mem [DEPTH];
  logic [AWIDTH-1:0] ram_addr_q = '0;
  always @(posedge clock) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
    ram_addr_q <= bus.ram_addr;
  end
  assign bus.ram_dout = ram_mem[ram_addr_q];

  // ---------------- reference model ----------------
  logic [DWIDTH-1:0] m_mem [DEPTH];
  int                m_last;      // last granted port
  int                since_rst;   // cycles since reset release
  bit                m_pv0, m_pv1;
  logic [DWIDTH-1:0] m_pd;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  // snapshots of the last checked cycle
  logic              s_ready0, s_ready1, s_rsp0_valid, s_rsp1_valid, s_we, s_done;
  logic [AWIDTH-1:0] s_addr;
  logic [DWIDTH-1:0] s_din, s_rsp0_dout, s_rsp1_dout;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Entered just after a rising edge; drives inputs, checks at the falling
  // edge, advances the model, returns just after the next rising edge.
  task automatic cycle(input bit v0, input bit w0, input logic [AWIDTH-1:0] a0,
                       input logic [DWIDTH-1:0] d0,
                       input bit v1, input bit w1, input logic [AWIDTH-1:0] a1,
                       input logic [DWIDTH-1:0] d1);
    int                g;
    bit                in_init;
    bit                ew;
    logic [AWIDTH-1:0] ea;
    logic [DWIDTH-1:0] ed;
    bit                nv0, nv1;
    logic [DWIDTH-1:0] nd;
    bus.req0_valid = v0; bus.req0_we = w0; bus.req0_addr = a0; bus.req0_din = d0;
    bus.req1_valid = v1; bus.req1_we = w1; bus.req1_addr = a1; bus.req1_din = d1;
    @(negedge clock);
    s_ready0 = bus.req0_ready;  s_ready1 = bus.req1_ready;
    s_rsp0_valid = bus.rsp0_valid; s_rsp1_valid = bus.rsp1_valid;
    s_rsp0_dout = bus.rsp0_dout; s_rsp1_dout = bus.rsp1_dout;
    s_we = bus.ram_we; s_addr = bus.ram_addr; s_din = bus.ram_din; s_done = bus.init_done;
`ifdef ARB_RAM_INIT_EN
    in_init = (since_rst < DEPTH);
`else
    in_init = 1'b0;
`endif
    g = -1; ew = 1'b0; ea = '0; ed = '0;
    if (in_init) begin
      ew = 1'b1;
      ea = AWIDTH'(since_rst);
    end else if (v0 && v1) g = (m_last == 0) ? 1 : 0;
    else if (v0)           g = 0;
    else if (v1)           g = 1;
    if (g == 0)      begin ew = w0; ea = a0; ed = d0; end
    else if (g == 1) begin ew = w1; ea = a1; ed = d1; end

    check_eq("ready0", s_ready0, g == 0);
    check_eq("ready1", s_ready1, g == 1);
    check_eq("ram_we", s_we, ew);
    check_eq("ram_addr", s_addr, ea);
    check_eq("ram_din", s_din, ed);
    check_eq("init_done", s_done, !in_init);
    check_eq("rsp0_valid", s_rsp0_valid, m_pv0);
    check_eq("rsp1_valid", s_rsp1_valid, m_pv1);
    if (m_pv0) check_eq("rsp0_dout", s_rsp0_dout, m_pd);
    if (m_pv1) check_eq("rsp1_dout", s_rsp1_dout, m_pd);

    nv0 = 1'b0; nv1 = 1'b0; nd = '0;
    if (in_init) m_mem[ea] = '0;
    if (g >= 0) begin
      m_last = g;
      if (ew) m_mem[ea] = ed;
      else begin
        nd = m_mem[ea];
        if (g == 0) nv0 = 1'b1; else nv1 = 1'b1;
      end
    end
    m_pv0 = nv0; m_pv1 = nv1; m_pd = nd;
    if (since_rst < 1000000) since_rst++;
    @(posedge clock); #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, AWIDTH'($urandom), DWIDTH'($urandom),
          1'b0, 1'b0, AWIDTH'($urandom), DWIDTH'($urandom));
  endtask

  // Hold reset for 'hold' cycles, checking the quiet outputs, then release.
  task automatic do_reset(input int hold);
    reset = 1'b1;
    m_last = 1; m_pv0 = 1'b0; m_pv1 = 1'b0; since_rst = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_eq("rst_ready0", bus.req0_ready, 1'b0);
      check_eq("rst_ready1", bus.req1_ready, 1'b0);
      check_eq("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
      check_eq("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
      check_eq("rst_ram_we", bus.ram_we, 1'b0);
`ifdef ARB_RAM_INIT_EN
      check_eq("rst_init_done", bus.init_done, 1'b0);
`else
      check_eq("rst_init_done", bus.init_done, 1'b1);
`endif
      @(posedge clock); #1;
    end
    reset = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_din = '0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_din = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = DWIDTH'($urandom_range(1, (1 << DWIDTH) - 1));
      m_mem[i]   = ram_mem[i];
    end
    @(posedge clock); #1;

    // Reset with a read already pending on port 0.
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 3'd2;
    do_reset(3);
`ifdef ARB_RAM_INIT_EN
    // Sweep: eight zero writes, requests ignored, then ARB.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'($urandom), 1'($urandom), AWIDTH'($urandom), DWIDTH'($urandom),
            1'($urandom), 1'($urandom), AWIDTH'($urandom), DWIDTH'($urandom));
      check_eq("init_sweep_addr", s_addr, i);
      check_eq("init_sweep_we", s_we, 1'b1);
      check_eq("init_sweep_din", s_din, 0);
    end
    cycle(1'b1, 1'b0, 3'd5, '0, 1'b0, 1'b0, '0, '0);
    check_eq("init_done_c9", s_done, 1'b1);
    check_eq("init_read_ready", s_ready0, 1'b1);
    idle();
    check_eq("init_read5_valid", s_rsp0_valid, 1'b1);
    check_eq("init_read5_dout", s_rsp0_dout, 0);
`else
    cycle(1'b1, 1'b0, 3'd2, '0, 1'b0, 1'b0, '0, '0);
    check_eq("noinit_first_ready0", s_ready0, 1'b1);
    check_eq("noinit_init_done", s_done, 1'b1);
    idle();
`endif

    // Single port write then read.
    cycle(1'b1, 1'b1, 3'd3, 14'h1ABC, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 3'd3, 14'h0000, 1'b0, 1'b0, '0, '0);
    idle();
    check_eq("sp_rsp0_valid", s_rsp0_valid, 1'b1);
    check_eq("sp_rsp0_dout", s_rsp0_dout, 14'h1ABC);
    check_eq("sp_rsp1_valid", s_rsp1_valid, 1'b0);

    // Contention straight after reset: grants 0,1,0,1.
    do_reset(2);
`ifdef ARB_RAM_INIT_EN
    for (int i = 0; i < DEPTH; i++) idle();
`endif
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, AWIDTH'($urandom), '0, 1'b1, 1'b0, AWIDTH'($urandom), '0);
      check_eq("cont_ready0", s_ready0, (k % 2) == 0);
      check_eq("cont_ready1", s_ready1, (k % 2) == 1);
    end
    idle();

    // Port 1 writes, port 0 reads the same address the next cycle.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 3'd7, 14'h0055);
    cycle(1'b1, 1'b0, 3'd7, '0, 1'b0, 1'b0, '0, '0);
    idle();
    check_eq("xp_rsp0_valid", s_rsp0_valid, 1'b1);
    check_eq("xp_rsp0_dout", s_rsp0_dout, 14'h0055);

    // Reset while a read response is due.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 3'd1, '0);
    check_eq("inflight_due", bus.rsp1_valid, 1'b1);
    do_reset(2);
`ifdef ARB_RAM_INIT_EN
    for (int i = 0; i < 4; i++) idle();
    do_reset(2);   // INIT was at address 4
    idle();
    check_eq("init_restart_addr", s_addr, 0);
    check_eq("init_restart_we", s_we, 1'b1);
    for (int i = 1; i < DEPTH; i++) idle();
`endif
    idle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 2));
      cycle($urandom_range(0, 9) < 6, 1'($urandom), AWIDTH'($urandom), DWIDTH'($urandom),
            $urandom_range(0, 9) < 6, 1'($urandom), AWIDTH'($urandom), DWIDTH'($urandom));
    end
    idle();

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
